// File: rtl/uart_operand_framer.sv
// uart_operand_framer
//   Assembles operand pairs for the Booth multiplier from the UART receiver's byte strobes.
//   Frame layout: HEADER, A (NB bytes, little-endian), B (NB bytes), CHK, where
//   NB = WIDTH/8 and CHK is the XOR of all operand bytes. The header is not part of CHK.
//   Operands are offered on a valid/ready handshake. Checksum, inter-byte timeout and
//   overrun (a byte arriving while operands are still pending) are reported as errors.
//
// Ports
//   CLK        system clock
//   RST_N      synchronous reset, active-low
//   RX_DV      one-cycle byte strobe from the UART receiver
//   RX_BYTE    received byte, valid while RX_DV=1
//   OP_READY   multiplier accepts the current operands
//   OP_VALID   operands valid, held until accepted
//   OP_A/OP_B  signed operands, updated only by a frame with a good checksum
//   FRAME_ERR  one-cycle error pulse
//   ERR_CODE   01 checksum, 10 timeout, 11 overrun; held between errors
//   BUSY       high whenever the framer is not idle
module uart_operand_framer #(
  parameter int         WIDTH        = 8,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         TIMEOUT_CLKS = 52080
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RX_DV,
  input  logic [7:0]       RX_BYTE,
  input  logic             OP_READY,
  output logic             OP_VALID,
  output logic [WIDTH-1:0] OP_A,
  output logic [WIDTH-1:0] OP_B,
  output logic             FRAME_ERR,
  output logic [1:0]       ERR_CODE,
  output logic             BUSY
);

  localparam int NB = WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
  // NB is at most 4, so a 2-bit byte index covers every operand width.
  localparam logic [1:0] IDX_LAST = 2'(NB - 1);

  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  typedef enum logic [2:0] {IDLE, GET_A, GET_B, GET_CHK, HOLD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       byte_idx, byte_idx_nxt;
  logic [7:0]       chk, chk_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [WIDTH-1:0] shadow_a, shadow_a_nxt;
  logic [WIDTH-1:0] shadow_b, shadow_b_nxt;
  logic [WIDTH-1:0] op_a_nxt, op_b_nxt;
  logic             frame_err_nxt;
  logic [1:0]       err_code_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      byte_idx  <= '0;
      chk       <= '0;
      timer     <= '0;
      shadow_a  <= '0;
      shadow_b  <= '0;
      OP_A      <= '0;
      OP_B      <= '0;
      FRAME_ERR <= 1'b0;
      ERR_CODE  <= '0;
    end else begin
      state     <= state_nxt;
      byte_idx  <= byte_idx_nxt;
      chk       <= chk_nxt;
      timer     <= timer_nxt;
      shadow_a  <= shadow_a_nxt;
      shadow_b  <= shadow_b_nxt;
      OP_A      <= op_a_nxt;
      OP_B      <= op_b_nxt;
      FRAME_ERR <= frame_err_nxt;
      ERR_CODE  <= err_code_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    byte_idx_nxt  = byte_idx;
    chk_nxt       = chk;
    timer_nxt     = timer;
    shadow_a_nxt  = shadow_a;
    shadow_b_nxt  = shadow_b;
    op_a_nxt      = OP_A;
    op_b_nxt      = OP_B;
    frame_err_nxt = 1'b0;
    err_code_nxt  = ERR_CODE;

    case (state)
      IDLE: begin
        if (RX_DV && RX_BYTE == HEADER) begin
          state_nxt    = GET_A;
          byte_idx_nxt = '0;
          chk_nxt      = '0;
          timer_nxt    = '0;
        end
      end

      GET_A, GET_B: begin
        if (RX_DV) begin
          chk_nxt   = chk ^ RX_BYTE;
          timer_nxt = '0;
          for (int i = 0; i < NB; i++) begin
            if (byte_idx == 2'(i)) begin
              if (state == GET_A) shadow_a_nxt[i*8 +: 8] = RX_BYTE;
              else                shadow_b_nxt[i*8 +: 8] = RX_BYTE;
            end
          end
          if (byte_idx == IDX_LAST) begin
            byte_idx_nxt = '0;
            state_nxt    = (state == GET_A) ? GET_B : GET_CHK;
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          err_code_nxt  = ERR_TIMEOUT;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      GET_CHK: begin
        if (RX_DV) begin
          timer_nxt = '0;
          if (RX_BYTE == chk) begin
            op_a_nxt  = shadow_a;
            op_b_nxt  = shadow_b;
            state_nxt = HOLD;
          end else begin
            state_nxt     = IDLE;
            frame_err_nxt = 1'b1;
            err_code_nxt  = ERR_CHECKSUM;
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
          err_code_nxt  = ERR_TIMEOUT;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      HOLD: begin
        // A byte here is always an overrun, even when the handshake completes on the
        // same edge; it is never reinterpreted as the next frame's header.
        if (RX_DV) begin
          frame_err_nxt = 1'b1;
          err_code_nxt  = ERR_OVERRUN;
        end
        if (OP_READY) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign OP_VALID = (state == HOLD);
  assign BUSY     = (state != IDLE);

endmodule
